// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver slice.
// Frame-walker states and the parity function.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_e;

    // Expected parity bit for up to 9 data bits (zero-extend narrower words).
    function automatic logic parity_bit(input logic [8:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through head.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [$clog2(DEPTH):0] count_next
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full       = (count_q == DEPTH_C);
    assign empty      = (count_q == '0);
    assign rd_data    = empty ? '0 : mem_q[rd_ptr_q];
    assign count_next = count_d;

    // Accept/advance decisions and next pointer/count values.
    always_comb begin
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; the head is masked while empty so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver feeding a receive FIFO.
// Checks start/parity/stop, keeps sticky error flags, drives RTS from occupancy.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int RTS_THRESH = FIFO_DEPTH - 1
) (
    input  logic                 baud_clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rx_buffer_empty,
    output logic                 rx_buffer_full,
    output logic                 rts,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    input  logic                 err_clr
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [CW-1:0] RTS_T    = CW'(RTS_THRESH);
    localparam logic          ODD      = (PARITY_ODD != 0);

    state_e               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 rx_meta_q, rx_meta_d;
    logic                 rx_s_q, rx_s_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q, overrun_d;
    logic                 rts_q, rts_d;

    logic                 push;
    logic                 fe_set;
    logic                 pe_set;
    logic                 ov_set;
    logic                 full;
    logic                 empty;
    logic [CW-1:0]        count_next;

    // Frame walker: mid-bit sampling driven by the oversample tick counter.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        push    = 1'b0;
        fe_set  = 1'b0;
        pe_set  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    tick_d  = '0;
                end
            end
            START: begin
                if (tick_q == HALF_M1) begin
                    if (!rx_s_q) begin
                        state_d = DATA;
                        tick_d  = '0;
                        bit_d   = '0;
                        perr_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            DATA: begin
                if (tick_q == FULL_M1) begin
                    tick_d  = '0;
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                        end else begin
                            state_d = STOP;
                        end
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            PARITY: begin
                if (tick_q == FULL_M1) begin
                    tick_d  = '0;
                    state_d = STOP;
                    if (rx_s_q != parity_bit(9'(shift_q), ODD)) begin
                        perr_d = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            STOP: begin
                if (tick_q == FULL_M1) begin
                    tick_d = '0;
                    if (!rx_s_q) begin
                        fe_set  = 1'b1;
                        state_d = BREAK;
                    end else if (perr_q) begin
                        pe_set  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            BREAK: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Synchroniser, sticky flags (set beats clear) and registered RTS.
    always_comb begin
        rx_meta_d    = rx;
        rx_s_d       = rx_meta_q;
        ov_set       = push && full && !rd_en;
        frame_err_d  = fe_set | (frame_err_q & ~err_clr);
        parity_err_d = pe_set | (parity_err_q & ~err_clr);
        overrun_d    = ov_set | (overrun_q & ~err_clr);
        rts_d        = (count_next < RTS_T);
    end

    // State and status registers.
    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            tick_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            rts_q        <= 1'b1;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            perr_q       <= perr_d;
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
            rts_q        <= rts_d;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (baud_clk),
        .rst        (rst),
        .push       (push),
        .pop        (rd_en),
        .wr_data    (shift_q),
        .rd_data    (rd_data),
        .full       (full),
        .empty      (empty),
        .count_next (count_next)
    );

    assign rx_buffer_empty = empty;
    assign rx_buffer_full  = full;
    assign rts             = rts_q;
    assign frame_err       = frame_err_q;
    assign parity_err      = parity_err_q;
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: 8N1 receiver plus an even-parity receiver sharing the clock.
// Expected values are hand-derived frame contents, flags and FIFO states.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    logic       clk;
    logic       rst;
    logic       rx_a, rd_en_a, err_clr_a;
    logic [7:0] rd_data_a;
    logic       empty_a, full_a, rts_a, fe_a, pe_a, ov_a;
    logic       rx_p, rd_en_p, err_clr_p;
    logic [7:0] rd_data_p;
    logic       empty_p, full_p, rts_p, fe_p, pe_p, ov_p;

    int passed = 0;
    int total  = 0;

    uart_rx_fifo dut (
        .baud_clk        (clk),
        .rst             (rst),
        .rx              (rx_a),
        .rd_en           (rd_en_a),
        .rd_data         (rd_data_a),
        .rx_buffer_empty (empty_a),
        .rx_buffer_full  (full_a),
        .rts             (rts_a),
        .frame_err       (fe_a),
        .parity_err      (pe_a),
        .overrun         (ov_a),
        .err_clr         (err_clr_a)
    );

    uart_rx_fifo #(.PARITY_EN(1), .PARITY_ODD(0)) dut_p (
        .baud_clk        (clk),
        .rst             (rst),
        .rx              (rx_p),
        .rd_en           (rd_en_p),
        .rd_data         (rd_data_p),
        .rx_buffer_empty (empty_p),
        .rx_buffer_full  (full_p),
        .rts             (rts_p),
        .frame_err       (fe_p),
        .parity_err      (pe_p),
        .overrun         (ov_p),
        .err_clr         (err_clr_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // mode 0: plain frame, 1: probe the push edge, 2: pop in the push cycle
    task automatic send_a(input logic [7:0] d, input logic stop,
                          input int mode);
        rx_a = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            rx_a = d[i];
            tick(16);
        end
        rx_a = stop;
        if (mode == 1) begin
            tick(10);
            chk("push_edge_pre", 32'(empty_a), 32'd1);
            tick(1);
            chk("push_edge_empty", 32'(empty_a), 32'd0);
            chk("push_edge_data", 32'(rd_data_a), 32'(d));
            tick(5);
        end else if (mode == 2) begin
            tick(10);
            rd_en_a = 1'b1;
            tick(1);
            rd_en_a = 1'b0;
            tick(5);
        end else begin
            tick(16);
        end
    endtask

    task automatic send_p(input logic [7:0] d, input logic par);
        rx_p = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            rx_p = d[i];
            tick(16);
        end
        rx_p = par;
        tick(16);
        rx_p = 1'b1;
        tick(16);
    endtask

    task automatic pop_a;
        rd_en_a = 1'b1;
        tick(1);
        rd_en_a = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        rx_a      = 1'b1;
        rx_p      = 1'b1;
        rd_en_a   = 1'b0;
        rd_en_p   = 1'b0;
        err_clr_a = 1'b0;
        err_clr_p = 1'b0;
        tick(3);
        chk("rst_rd_data", 32'(rd_data_a), 32'h0);
        chk("rst_empty", 32'(empty_a), 32'd1);
        chk("rst_full", 32'(full_a), 32'd0);
        chk("rst_rts", 32'(rts_a), 32'd1);
        chk("rst_flags", 32'({fe_a, pe_a, ov_a}), 32'd0);
        rst = 1'b0;
        tick(5);

        send_a(8'hA5, 1'b1, 1);
        pop_a();
        chk("a5_pop_empty", 32'(empty_a), 32'd1);

        rx_a = 1'b0;
        tick(5);
        rx_a = 1'b1;
        tick(40);
        chk("glitch_empty", 32'(empty_a), 32'd1);
        chk("glitch_flags", 32'({fe_a, pe_a, ov_a}), 32'd0);
        chk("glitch_state", 32'(dut.state_q), 32'(IDLE));

        send_p(8'h03, 1'b1);
        tick(2);
        chk("par_err_set", 32'(pe_p), 32'd1);
        chk("par_err_empty", 32'(empty_p), 32'd1);
        chk("par_no_fe", 32'(fe_p), 32'd0);
        err_clr_p = 1'b1;
        tick(1);
        err_clr_p = 1'b0;
        chk("par_err_clr", 32'(pe_p), 32'd0);
        send_p(8'h03, 1'b0);
        tick(2);
        chk("par_ok_empty", 32'(empty_p), 32'd0);
        chk("par_ok_data", 32'(rd_data_p), 32'h03);
        chk("par_ok_flag", 32'(pe_p), 32'd0);

        send_a(8'h3C, 1'b0, 0);
        tick(2);
        chk("brk_fe_set", 32'(fe_a), 32'd1);
        chk("brk_empty", 32'(empty_a), 32'd1);
        err_clr_a = 1'b1;
        tick(1);
        err_clr_a = 1'b0;
        chk("brk_fe_clr", 32'(fe_a), 32'd0);
        tick(40 * 16);
        chk("brk_no_refire", 32'(fe_a), 32'd0);
        chk("brk_no_push", 32'(empty_a), 32'd1);
        rx_a = 1'b1;
        tick(32);
        send_a(8'h5A, 1'b1, 0);
        tick(2);
        chk("brk_5a_data", 32'(rd_data_a), 32'h5A);
        chk("brk_5a_fe", 32'(fe_a), 32'd0);
        pop_a();

        for (int k = 1; k <= 5; k++) begin
            send_a(8'(k), 1'b1, 0);
            tick(1);
            if (k == 2) chk("ov_rts_2", 32'(rts_a), 32'd1);
            if (k == 3) begin
                chk("ov_rts_3", 32'(rts_a), 32'd0);
                chk("ov_full_3", 32'(full_a), 32'd0);
            end
            if (k == 4) begin
                chk("ov_full_4", 32'(full_a), 32'd1);
                chk("ov_flag_4", 32'(ov_a), 32'd0);
            end
            if (k == 5) begin
                chk("ov_flag_5", 32'(ov_a), 32'd1);
                chk("ov_full_5", 32'(full_a), 32'd1);
            end
        end
        for (int k = 1; k <= 4; k++) begin
            chk("ov_pop_data", 32'(rd_data_a), 32'(k));
            pop_a();
        end
        chk("ov_drained", 32'(empty_a), 32'd1);
        chk("ov_rts_back", 32'(rts_a), 32'd1);
        err_clr_a = 1'b1;
        tick(1);
        err_clr_a = 1'b0;
        chk("ov_clr", 32'(ov_a), 32'd0);

        for (int k = 0; k < 4; k++) begin
            send_a(8'h11 + 8'(k), 1'b1, 0);
        end
        chk("pp_full_pre", 32'(full_a), 32'd1);
        send_a(8'h77, 1'b1, 2);
        chk("pp_no_overrun", 32'(ov_a), 32'd0);
        chk("pp_still_full", 32'(full_a), 32'd1);
        chk("pp_head", 32'(rd_data_a), 32'h12);
        pop_a();
        pop_a();
        pop_a();
        chk("pp_last", 32'(rd_data_a), 32'h77);
        pop_a();
        chk("pp_empty", 32'(empty_a), 32'd1);

        send_p(8'h03, 1'b1);
        send_a(8'h42, 1'b1, 0);
        chk("mr_pre_empty", 32'(empty_a), 32'd0);
        chk("mr_pre_pe", 32'(pe_p), 32'd1);
        rx_a = 1'b0;
        tick(16);
        rx_a = 1'b1;
        tick(20);
        rst = 1'b1;
        #1;
        chk("mr_rd_data", 32'(rd_data_a), 32'h0);
        chk("mr_empty", 32'(empty_a), 32'd1);
        chk("mr_full", 32'(full_a), 32'd0);
        chk("mr_rts", 32'(rts_a), 32'd1);
        chk("mr_flags_a", 32'({fe_a, pe_a, ov_a}), 32'd0);
        chk("mr_flags_p", 32'({fe_p, pe_p, ov_p}), 32'd0);
        chk("mr_empty_p", 32'(empty_p), 32'd1);
        tick(3);
        rst = 1'b0;
        tick(200);
        chk("mr_aborted", 32'(empty_a), 32'd1);
        chk("mr_state", 32'(dut.state_q), 32'(IDLE));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
